// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg
// Shared types and helpers for the tic-tac-toe controller.
//   cell_t   : per-square code (EMPTY / O = user / X = FPGA)
//   result_t : game outcome code (NONE / XWIN / OWIN)
//   state_t  : controller FSM states
// Board layout: square n (1..9) occupies bits [19-2n:18-2n], so square 1
// is the top two bits and square 9 the bottom two.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_O     = 2'b01,
    CELL_X     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_XWIN = 2'd1,
    RES_OWIN = 2'd2
  } result_t;

  typedef enum logic [2:0] {
    USER_WAIT,
    USER_CHK,
    AI_REQ,
    AI_WAIT,
    AI_CHK,
    DONE
  } state_t;

  function automatic logic is_square(input logic [3:0] sq);
    return (sq >= 4'd1) && (sq <= 4'd9);
  endfunction

  // Out-of-range squares read back as empty; callers gate with is_square.
  function automatic logic [1:0] get_cell(input logic [17:0] b, input logic [3:0] sq);
    logic [1:0] c;
    c = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      if (sq == 4'(k)) c = b[18-2*k +: 2];
    end
    return c;
  endfunction

  // Writing to an out-of-range square leaves the board untouched.
  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] sq,
                                           input logic [1:0] c);
    logic [17:0] r;
    r = b;
    for (int k = 1; k <= 9; k++) begin
      if (sq == 4'(k)) r[18-2*k +: 2] = c;
    end
    return r;
  endfunction

  // Lowest-numbered empty square, or 0 when the board is full.
  function automatic logic [3:0] lowest_empty(input logic [17:0] b);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if (b[18-2*k +: 2] == CELL_EMPTY) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if
// Bundles the user, move-engine and result signals of game_ctrl.
//   slave  : the controller side (game_ctrl)
//   master : the environment side (user input, move engine, result consumer)
// Signal names keep their i_/o_ prefixes as seen from the controller.
interface game_ctrl_if;
  logic [3:0]  i_move;
  logic        i_validmove_stb;
  logic        o_needinput;
  logic [17:0] o_board;
  logic [1:0]  o_result;
  logic        o_isdraw;
  logic        o_result_stb;
  logic        o_ai_start;
  logic [3:0]  i_ai_move;
  logic        i_ai_done;
  logic        i_newgame;
  logic        o_badmove_stb;

  modport slave (
    input  i_move, i_validmove_stb, i_ai_move, i_ai_done, i_newgame,
    output o_needinput, o_board, o_result, o_isdraw, o_result_stb,
           o_ai_start, o_badmove_stb
  );

  modport master (
    output i_move, i_validmove_stb, i_ai_move, i_ai_done, i_newgame,
    input  o_needinput, o_board, o_result, o_isdraw, o_result_stb,
           o_ai_start, o_badmove_stb
  );
endinterface

// File: rtl/win_check.sv
// win_check
// Purely combinational line checker for an 18-bit tic-tac-toe board.
//   board : 9 squares x 2 bits, square n at bits [19-2n:18-2n]
//   xwin  : some line holds three X
//   owin  : some line holds three O
//   full  : no square is empty
module win_check
  import game_ctrl_pkg::*;
(
  input  logic [17:0] board,
  output logic        xwin,
  output logic        owin,
  output logic        full
);

  // 'who' is never EMPTY, so equality to it also implies non-empty.
  function automatic logic line_hit(input logic [17:0] b, input logic [1:0] who);
    logic [1:0] c [1:9];
    for (int k = 1; k <= 9; k++) c[k] = b[18-2*k +: 2];
    return (c[1] == who && c[2] == who && c[3] == who) ||
           (c[4] == who && c[5] == who && c[6] == who) ||
           (c[7] == who && c[8] == who && c[9] == who) ||
           (c[1] == who && c[4] == who && c[7] == who) ||
           (c[2] == who && c[5] == who && c[8] == who) ||
           (c[3] == who && c[6] == who && c[9] == who) ||
           (c[1] == who && c[5] == who && c[9] == who) ||
           (c[3] == who && c[5] == who && c[7] == who);
  endfunction

  assign xwin = line_hit(board, CELL_X);
  assign owin = line_hit(board, CELL_O);

  always_comb begin
    full = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (board[18-2*k +: 2] == CELL_EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
// Tic-tac-toe game controller: accepts user (O) moves, requests moves from an
// external move engine for the FPGA (X), falls back to the lowest empty square
// on a bad or late engine answer, and reports wins and draws.
// Parameters:
//   FPGA_FIRST : 1 -> X opens every game, 0 -> user opens
//   AI_TIMEOUT : cycles spent in AI_WAIT before the fallback move is used
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : game_ctrl_if.slave (user move, engine handshake, board/result)
// All outputs are registered.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int FPGA_FIRST = 0,
  parameter int AI_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  game_ctrl_if.slave  bus
);

  localparam int CNT_W = (AI_TIMEOUT > 1) ? $clog2(AI_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AI_TIMEOUT - 1);
  localparam state_t START_STATE = (FPGA_FIRST != 0) ? AI_REQ : USER_WAIT;

  state_t             state_q, state_d;
  logic [17:0]        board_q, board_d;
  logic [1:0]         result_q, result_d;
  logic               isdraw_q, isdraw_d;
  logic               needinput_q, needinput_d;
  logic               badmove_q, badmove_d;
  logic               ai_start_q, ai_start_d;
  logic               result_stb_q, result_stb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic xwin, owin, full;
  logic user_ok, ai_ok;

  win_check u_win_check (
    .board (board_q),
    .xwin  (xwin),
    .owin  (owin),
    .full  (full)
  );

  assign user_ok = is_square(bus.i_move) &&
                   (get_cell(board_q, bus.i_move) == CELL_EMPTY);
  assign ai_ok   = is_square(bus.i_ai_move) &&
                   (get_cell(board_q, bus.i_ai_move) == CELL_EMPTY);

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    result_d     = result_q;
    isdraw_d     = isdraw_q;
    badmove_d    = 1'b0;
    result_stb_d = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      USER_WAIT: begin
        if (bus.i_validmove_stb) begin
          if (user_ok) begin
            board_d = set_cell(board_q, bus.i_move, CELL_O);
            state_d = USER_CHK;
          end else begin
            badmove_d = 1'b1;
          end
        end
      end

      USER_CHK: begin
        // Win is tested before full so a winning last move is not a draw.
        if (owin) begin
          result_d     = RES_OWIN;
          result_stb_d = 1'b1;
          state_d      = DONE;
        end else if (full) begin
          isdraw_d     = 1'b1;
          result_stb_d = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = AI_REQ;
        end
      end

      AI_REQ: begin
        cnt_d = '0;
        // ai_start_q is already high on a normal entry; straight out of reset
        // it is low, so stay one extra cycle to issue the request.
        if (ai_start_q) state_d = AI_WAIT;
      end

      AI_WAIT: begin
        if (bus.i_ai_done && ai_ok) begin
          board_d = set_cell(board_q, bus.i_ai_move, CELL_X);
          state_d = AI_CHK;
        end else if (bus.i_ai_done || (cnt_q == CNT_LAST)) begin
          board_d = set_cell(board_q, lowest_empty(board_q), CELL_X);
          state_d = AI_CHK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      AI_CHK: begin
        // One strobe both reports the X move and, on game end, the DONE entry.
        result_stb_d = 1'b1;
        if (xwin) begin
          result_d = RES_XWIN;
          state_d  = DONE;
        end else if (full) begin
          isdraw_d = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = USER_WAIT;
        end
      end

      DONE: begin
        if (bus.i_newgame) begin
          board_d  = '0;
          result_d = RES_NONE;
          isdraw_d = 1'b0;
          state_d  = START_STATE;
        end
      end

      default: state_d = START_STATE;
    endcase

    needinput_d = (state_d == USER_WAIT);
    ai_start_d  = (state_d == AI_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= START_STATE;
      board_q      <= '0;
      result_q     <= RES_NONE;
      isdraw_q     <= 1'b0;
      needinput_q  <= 1'b0;
      badmove_q    <= 1'b0;
      ai_start_q   <= 1'b0;
      result_stb_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      result_q     <= result_d;
      isdraw_q     <= isdraw_d;
      needinput_q  <= needinput_d;
      badmove_q    <= badmove_d;
      ai_start_q   <= ai_start_d;
      result_stb_q <= result_stb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.o_needinput   = needinput_q;
  assign bus.o_board       = board_q;
  assign bus.o_result      = result_q;
  assign bus.o_isdraw      = isdraw_q;
  assign bus.o_result_stb  = result_stb_q;
  assign bus.o_ai_start    = ai_start_q;
  assign bus.o_badmove_stb = badmove_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
Parameters:
REQ-001 FPGA_FIRST, 0, when 1 the FPGA (X) moves first in every game, otherwise the user (O) moves first.
REQ-002 AI_TIMEOUT, 1024, maximum number of cycles to wait for i_ai_done before the fallback move is used.

Ports:
REQ-003 i_clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active low.
REQ-005 i_move  in  4  user move, square number 1..9.
REQ-006 i_validmove_stb  in  1  one-cycle strobe; i_move is valid in this cycle.
REQ-007 o_needinput  out  1  high while the controller waits for a user move.
REQ-008 o_board  out  18  board state; square n occupies bits [19-2n:18-2n]; 00 empty, 01 O (user), 10 X (FPGA).
REQ-009 o_result  out  2  0 NONE, 1 XWIN, 2 OWIN.
REQ-010 o_isdraw  out  1  board full with no winner.
REQ-011 o_result_stb  out  1  one-cycle strobe; o_board, o_result and o_isdraw are valid in this cycle.
REQ-012 o_ai_start  out  1  one-cycle strobe requesting a move from the move engine.
REQ-013 i_ai_move  in  4  move-engine square 1..9; sampled when i_ai_done is high.
REQ-014 i_ai_done  in  1  one-cycle strobe from the move engine.
REQ-015 i_newgame  in  1  level signal; clears the board and starts a new game while in DONE.
REQ-016 o_badmove_stb  out  1  one-cycle strobe; the last user move was rejected.

Function
REQ-017 The FSM SHALL have these states: USER_WAIT, USER_CHK, AI_REQ, AI_WAIT, AI_CHK, DONE.
REQ-018 USER_WAIT: o_needinput=1; on i_validmove_stb with i_move in 1..9 and the square empty, the controller SHALL write 01 to the square and go to USER_CHK the next cycle.
REQ-019 In USER_WAIT, a move of 0, a move of 10..15, or a move to an occupied square SHALL leave the board unchanged, pulse o_badmove_stb the next cycle, and keep the FSM in USER_WAIT.
REQ-020 o_needinput SHALL deassert in the cycle after an accepted move strobe and stay low until the FSM next re-enters USER_WAIT.
REQ-021 USER_CHK: a completed O line SHALL set o_result=2 and go to DONE; otherwise a full board SHALL set o_isdraw=1 and go to DONE; otherwise the FSM SHALL go to AI_REQ.
REQ-022 AI_REQ: o_ai_start SHALL pulse for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to AI_WAIT.
REQ-023 AI_WAIT: on i_ai_done with i_ai_move in 1..9 and the square empty, the controller SHALL write 10 to the square and go to AI_CHK.
REQ-024 Fallback: if i_ai_done carries an illegal or occupied square, or the counter reaches AI_TIMEOUT-1, the controller SHALL write X to the lowest-numbered empty square and go to AI_CHK.
REQ-025 An i_ai_done outside AI_WAIT SHALL be ignored.
REQ-026 AI_CHK: the controller SHALL pulse o_result_stb; a completed X line SHALL set o_result=1 and go to DONE; a full board SHALL set o_isdraw=1 and go to DONE; otherwise the FSM SHALL go to USER_WAIT.
REQ-027 Entry to DONE SHALL pulse o_result_stb once, in the entry cycle, with final values; when the entry is from AI_CHK, that single pulse SHALL serve both REQ-026 and this requirement.
REQ-028 DONE: the outputs SHALL hold; i_newgame=1 SHALL clear the board, o_result and o_isdraw, then go to AI_REQ if FPGA_FIRST=1, else to USER_WAIT.
REQ-029 Win check: a win is any of the 8 lines (123,456,789,147,258,369,159,357) with all three squares equal and non-empty; a win SHALL take precedence over a draw.
REQ-030 Latency: an accepted user move SHALL reach AI_REQ in 2 cycles when the game has not ended.

Reset
REQ-031 While i_rst_n=0, the outputs SHALL be: o_board=0, o_result=0, o_isdraw=0, o_needinput=0, and all strobes 0; the counter SHALL be 0.
REQ-032 On i_rst_n=0, the FSM SHALL go to USER_WAIT, or to AI_REQ if FPGA_FIRST=1.
REQ-033 A reset asserted at any point, including mid-AI_WAIT, SHALL abandon the game immediately; a late i_ai_done after reset SHALL be ignored per REQ-025.

Structure
REQ-034 A shared package SHALL hold the cell codes (EMPTY/O/X), the result codes (NONE/XWIN/OWIN) and the state enumeration.
REQ-035 The combinational line checker SHALL be the sub-module win_check: input 18-bit board, outputs xwin, owin and full.

Verification
REQ-036 Reset, then i_move=5 strobed -> board bits[9:8]=01, o_ai_start pulses 2 cycles later.
REQ-037 i_move=5 again while square 5 is occupied -> o_badmove_stb=1 for one cycle, board unchanged, o_needinput stays 1.
REQ-038 i_move=0 and i_move=12 -> both rejected with o_badmove_stb.
REQ-039 User plays 1,2,3 and the engine plays 4,5 -> o_result=2, single o_result_stb, FSM in DONE.
REQ-040 Engine never asserts i_ai_done, AI_TIMEOUT=16 -> after 16 cycles, X is placed in the lowest empty square.
REQ-041 Engine returns an occupied square -> fallback placement; full board with no line -> o_isdraw=1, o_result=0.
